fila_ctrl: RTL and testbench
============================

// Module: fila_ctrl
// PURPOSE
//   Arbiter/sequencer in front of one 8-entry fila queue. Shares the enqueue side
//   between two producers (round-robin) and drains the queue into a registered
//   consumer output with a valid/ready handshake. Guarantees enqueue and dequeue
//   are never asserted to the queue in the same cycle, so the queue's length and
//   write index stay consistent. Sits between the producer/consumer logic and the fila.
// PARAMETERS
//   WIDTH  8  data width of producers, queue and consumer
//   DEPTH  8  queue capacity; q_len >= DEPTH is treated as full
// PORTS
//   clk_10KHz    in   1      system clock; all logic on posedge
//   reset        in   1      asynchronous, active-low reset (0 = reset)
//   p0_data      in   WIDTH  producer 0 data; held stable while p0_valid=1
//   p0_valid     in   1      producer 0 has data
//   p0_ready     out  1      producer 0 transfer completes at this edge
//   p1_data      in   WIDTH  producer 1 data
//   p1_valid     in   1      producer 1 has data
//   p1_ready     out  1      producer 1 transfer completes at this edge
//   c_data       out  WIDTH  consumer data, registered
//   c_valid      out  1      c_data holds an unread word
//   c_ready      in   1      consumer accepts c_data when c_valid=1
//   q_data_in    out  WIDTH  to fila data_in
//   q_enqueue    out  1      to fila enqueue_in
//   q_dequeue    out  1      to fila dequeue_in
//   q_data_out   in   WIDTH  from fila data_out
//   q_len        in   8      from fila len_out, unsigned
//   q_full       out  1      q_len >= DEPTH (combinational)
//   q_empty      out  1      q_len == 0 (combinational)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, rr pointer=P0, every registered output 0
//     (q_enqueue, q_dequeue, q_data_in, p0/p1_ready, c_data, c_valid). Top level
//     resets the fila from the same net (inverted), so both clear together;
//     a mid-operation reset abandons the operation, and the word is lost.
//   - FSM: IDLE -> ENQ -> IDLE; IDLE -> DEQ -> CAPT -> IDLE. All outputs are registered.
//   - Eligibility in IDLE: Pn if pn_valid && !q_full; D if !q_empty && !c_valid.
//   - Grant: round-robin over order P0, P1, D, starting at rr pointer. On grant,
//     the pointer moves to the requester after the winner. No eligible requester
//     means stay in IDLE with all strobes 0.
//   - Grant Pn: at the IDLE edge, q_data_in<=pn_data, q_enqueue<=1, pn_ready<=1,
//     state<=ENQ. ENQ lasts exactly 1 cycle. The fila writes at the ENQ-ending edge.
//     The FSM clears q_enqueue/pn_ready at that edge and returns to IDLE. q_len is
//     valid again in IDLE. Throughput is 1 enqueue per 2 cycles.
//   - Grant D: q_dequeue<=1, state<=DEQ (1 cycle). The fila updates data_out at the
//     DEQ-ending edge, and q_dequeue<=0, state<=CAPT. In CAPT, q_data_out is sampled:
//     c_data<=q_data_out, c_valid<=1, state<=IDLE. Latency is grant edge to c_valid=1:
//     2 cycles.
//   - Consumer: c_valid&&c_ready at an edge clears c_valid. c_data holds its value.
//     c_valid stays high, and c_data stays stable, until accepted.
//   - q_enqueue and q_dequeue are never 1 in the same cycle. Each is at most a
//     1-cycle pulse per operation.
//   - Full: producers wait (ready stays 0). Empty: no dequeue. q_len > DEPTH is
//     treated as full, with no wrap.
//   - A producer dropping valid without ready is legal and simply loses eligibility.
// TESTING
//   1 reset=0 mid-ENQ -> all outputs 0 at once, state IDLE; after release,
//     p0 0x11 -> q_enqueue pulse 1 cycle.
//   2 p0_valid & p1_valid held (0xA0/0xB0), empty queue, c_valid=1 -> enqueue
//     order A0,B0,A0,B0; p0_ready/p1_ready alternate every 2 cycles.
//   3 q_len=8 with p0_valid=1 -> p0_ready stays 0, q_enqueue=0, q_full=1 until
//     a dequeue completes.
//   4 queue holds 0x55,0x66, c_ready=1 -> c_data=0x55 then 0x66, each c_valid
//     2 cycles after its q_dequeue pulse.
//   5 c_ready=0 with words queued -> one word captured; no further q_dequeue;
//     c_data stable until c_ready=1.
//   6 random valid/ready for 10k cycles -> checker: never q_enqueue&q_dequeue,
//     FIFO order per word, no loss or duplication.

Source files
------------

// File: rtl/fila_ctrl.sv
`timescale 1ns/1ps
// fila_ctrl: round-robin enqueue arbiter and registered dequeue sequencer in front of one fila queue.
// Enqueue and dequeue are serialised through one FSM so the queue never sees both in a cycle.
module fila_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] p0_data,
  input  logic             p0_valid,
  output logic             p0_ready,
  input  logic [WIDTH-1:0] p1_data,
  input  logic             p1_valid,
  output logic             p1_ready,
  output logic [WIDTH-1:0] c_data,
  output logic             c_valid,
  input  logic             c_ready,
  output logic [WIDTH-1:0] q_data_in,
  output logic             q_enqueue,
  output logic             q_dequeue,
  input  logic [WIDTH-1:0] q_data_out,
  input  logic [7:0]       q_len,
  output logic             q_full,
  output logic             q_empty
);
  typedef enum logic [1:0] {IDLE, ENQ, DEQ, CAPT} state_t;
  localparam logic [7:0] DEPTH_L = 8'(DEPTH);
  state_t state_q, state_d;
  logic [1:0] rr_q, rr_d, nx1, nx2, win;
  logic [3:0] elig;
  logic [WIDTH-1:0] din_q, din_d, cd_q, cd_d;
  logic enq_q, enq_d, deq_q, deq_d, r0_q, r0_d, r1_q, r1_d, cv_q, cv_d;

  function automatic logic [1:0] nxt(input logic [1:0] r);
    return r == 2'd2 ? 2'd0 : r + 2'd1;
  endfunction

  assign q_full  = q_len >= DEPTH_L;
  assign q_empty = q_len == 8'd0;
  // requester index: 0 = P0, 1 = P1, 2 = dequeue; bit 3 pads the unused pointer code
  assign elig = {1'b0, !q_empty && !cv_q, p1_valid && !q_full, p0_valid && !q_full};
  assign nx1  = nxt(rr_q);
  assign nx2  = nxt(nx1);
  assign win  = elig[rr_q] ? rr_q : elig[nx1] ? nx1 : nx2;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    din_d   = din_q;
    cd_d    = cd_q;
    enq_d   = 1'b0;
    deq_d   = 1'b0;
    r0_d    = 1'b0;
    r1_d    = 1'b0;
    cv_d    = cv_q && !c_ready;
    case (state_q)
      IDLE: if (|elig) begin
        rr_d    = nxt(win);
        state_d = win == 2'd2 ? DEQ : ENQ;
        deq_d   = win == 2'd2;
        enq_d   = win != 2'd2;
        r0_d    = win == 2'd0;
        r1_d    = win == 2'd1;
        din_d   = win == 2'd0 ? p0_data : win == 2'd1 ? p1_data : din_q;
      end
      ENQ:  state_d = IDLE;
      DEQ:  state_d = CAPT;
      CAPT: begin
        cd_d    = q_data_out;
        cv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      din_q   <= '0;
      cd_q    <= '0;
      enq_q   <= 1'b0;
      deq_q   <= 1'b0;
      r0_q    <= 1'b0;
      r1_q    <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      din_q   <= din_d;
      cd_q    <= cd_d;
      enq_q   <= enq_d;
      deq_q   <= deq_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      cv_q    <= cv_d;
    end
  end

  assign q_data_in = din_q;
  assign q_enqueue = enq_q;
  assign q_dequeue = deq_q;
  assign p0_ready  = r0_q;
  assign p1_ready  = r1_q;
  assign c_data    = cd_q;
  assign c_valid   = cv_q;
endmodule

// File: tb/tb_fila_ctrl.sv
`timescale 1ns/1ps
// tb_fila_ctrl: directed scenarios plus a random soak against a word-level scoreboard
// and a behavioural fila queue attached to the controller.
module tb_fila_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] p0_data = 8'h00, p1_data = 8'h00;
  logic p0_valid = 1'b0, p1_valid = 1'b0, c_ready = 1'b0;
  logic p0_ready, p1_ready, c_valid, q_enqueue, q_dequeue, q_full, q_empty;
  logic [7:0] c_data, q_data_in, q_data_out, q_len;
  logic force_en = 1'b0;
  logic [7:0] force_len = 8'h00;

  always #5 clk = ~clk;

  fila_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_10KHz(clk), .reset(reset),
    .p0_data(p0_data), .p0_valid(p0_valid), .p0_ready(p0_ready),
    .p1_data(p1_data), .p1_valid(p1_valid), .p1_ready(p1_ready),
    .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .q_data_in(q_data_in), .q_enqueue(q_enqueue), .q_dequeue(q_dequeue),
    .q_data_out(q_data_out), .q_len(q_len), .q_full(q_full), .q_empty(q_empty)
  );

  // behavioural fila: push on enqueue, present the popped word on data_out
  logic [7:0] fq[$];
  logic [7:0] f_out = 8'h00, f_len = 8'h00;
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      fq.delete();
      f_out <= 8'h00;
      f_len <= 8'h00;
    end else begin
      if (q_enqueue) fq.push_back(q_data_in);
      if (q_dequeue && fq.size() > 0) begin
        f_out <= fq[0];
        fq.delete(0);
      end
      f_len <= 8'(fq.size());
    end
  end
  assign q_data_out = f_out;
  assign q_len = force_en ? force_len : f_len;

  int checks = 0, failures = 0;
  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {logic [7:0] w; int due;} pend_t;
  pend_t pend[$];
  pend_t pe;
  logic [7:0] sb[$], enq_log[$], acc_log[$];
  int lat_log[$];
  int xfers0 = 0, xfers1 = 0, deq_cnt = 0, cyc = 0, last_deq = 0;
  bit prev_enq = 0, prev_deq = 0, prev_cv = 0, prev_acc = 0;
  logic [7:0] prev_len = 8'h00, prev_cd = 8'h00, w_exp;

  // per-cycle checker: inputs settle at posedge+2, so the negedge sees the values of the coming edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      sb.delete();
      pend.delete();
      {prev_enq, prev_deq, prev_cv, prev_acc} = 4'b0;
      prev_len = 8'h00;
      prev_cd = 8'h00;
    end else begin
      chk(!(q_enqueue && q_dequeue), "enq_deq_exclusive", 32'({q_enqueue, q_dequeue}), 0);
      chk(q_full == (q_len >= 8), "q_full", 32'(q_full), 32'(q_len >= 8));
      chk(q_empty == (q_len == 0), "q_empty", 32'(q_empty), 32'(q_len == 0));
      chk(q_enqueue == (p0_ready || p1_ready) && !(p0_ready && p1_ready), "ready_matches_enq",
          32'({p0_ready, p1_ready, q_enqueue}), 32'({p0_ready, p1_ready, p0_ready || p1_ready}));
      if (q_enqueue) begin
        w_exp = p0_ready ? p0_data : p1_data;
        chk(!prev_enq && prev_len < 8, "enq_allowed", 32'(prev_len), 8);
        chk(q_data_in == w_exp, "q_data_in", 32'(q_data_in), 32'(w_exp));
        sb.push_back(w_exp);
        enq_log.push_back(q_data_in);
        if (p0_ready) xfers0++; else xfers1++;
      end
      if (q_dequeue) begin
        chk(!prev_deq && prev_len != 0 && !c_valid, "deq_allowed", 32'({prev_deq, c_valid}), 0);
        pe.w = fq.size() > 0 ? fq[0] : 8'h00;
        pe.due = cyc + 2;
        pend.push_back(pe);
        deq_cnt++;
        last_deq = cyc;
      end
      if (c_valid && !prev_cv) lat_log.push_back(cyc - last_deq);
      if (pend.size() > 0 && pend[0].due == cyc) begin
        chk(c_valid && c_data == pend[0].w, "capture", 32'(c_data), 32'(pend[0].w));
        pend.delete(0);
      end else chk(!(c_valid && !prev_cv), "spurious_c_valid", 32'(c_valid), 0);
      if (prev_cv && !prev_acc) chk(c_valid && c_data == prev_cd, "c_hold", 32'(c_data), 32'(prev_cd));
      prev_acc = c_valid && c_ready;
      if (prev_acc) begin
        chk(sb.size() > 0 && c_data == sb[0], "fifo_order", 32'(c_data), sb.size() > 0 ? 32'(sb[0]) : -1);
        if (sb.size() > 0) sb.delete(0);
        acc_log.push_back(c_data);
      end
      prev_enq = q_enqueue;
      prev_deq = q_dequeue;
      prev_cv = c_valid;
      prev_cd = c_data;
      prev_len = q_len;
    end
  end

  task automatic wait_rdy(input bit n);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = n ? p1_ready : p0_ready;
    end
    chk(ok, n ? "p1_ready_timeout" : "p0_ready_timeout", 32'(ok), 1);
  endtask

  task automatic drain();
    bit ok = 0;
    @(posedge clk); #2 c_ready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = sb.size() == 0 && !c_valid && q_len == 0;
    end
    chk(ok, "drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({q_enqueue, q_dequeue, p0_ready, p1_ready, c_valid} == 5'b0, name, 32'({q_enqueue, q_dequeue, p0_ready, p1_ready, c_valid}), 0);
    chk(q_data_in == 8'h00 && c_data == 8'h00, {name, "_data"}, 32'({q_data_in, c_data}), 0);
  endtask

  logic [7:0] exp2[4] = '{8'hA0, 8'hB0, 8'hA0, 8'hB0};
  int seen0, seen1;

  initial begin
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset_state");
    chk(q_empty == 1'b1, "reset_q_empty", 32'(q_empty), 1);
    @(posedge clk); #2 reset = 1'b1;

    // reset in the middle of an enqueue: outputs clear immediately
    @(posedge clk); #2 p0_data = 8'h33; p0_valid = 1'b1;
    wait_rdy(0);
    #1 reset = 1'b0;
    #1 chk_idle_outputs("mid_enq_reset");
    p0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // single enqueue after release: one-cycle pulse
    @(posedge clk); #2 p0_data = 8'h11; p0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk(q_enqueue && p0_ready && q_data_in == 8'h11, "t1_enq_pulse", 32'({q_enqueue, p0_ready, q_data_in}), 32'h311);
    @(posedge clk); #2 p0_valid = 1'b0;
    @(negedge clk);
    chk(!q_enqueue && !p0_ready, "t1_enq_end", 32'({q_enqueue, p0_ready}), 0);
    repeat (6) @(negedge clk);
    chk(c_valid && c_data == 8'h11, "t1_captured", 32'({c_valid, c_data}), 32'h111);

    // both producers held with c_valid=1: strict alternation
    enq_log.delete();
    @(posedge clk); #2 p0_data = 8'hA0; p1_data = 8'hB0; p0_valid = 1'b1; p1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk(p0_ready == (i == 1 || i == 5), "t2_p0_ready", 32'(p0_ready), 32'(i == 1 || i == 5));
      chk(p1_ready == (i == 3 || i == 7), "t2_p1_ready", 32'(p1_ready), 32'(i == 3 || i == 7));
    end
    @(posedge clk); #2 p0_valid = 1'b0; p1_valid = 1'b0;
    chk(enq_log.size() == 4, "t2_enq_count", enq_log.size(), 4);
    for (int i = 0; i < 4 && i < enq_log.size(); i++)
      chk(enq_log[i] == exp2[i], "t2_enq_order", 32'(enq_log[i]), 32'(exp2[i]));

    // fill to full; producer must wait
    @(posedge clk); #2 p0_data = 8'hC0; p0_valid = 1'b1;
    for (int i = 0; i < 30 && q_len != 8; i++) @(negedge clk);
    chk(q_len == 8, "t3_fill", 32'(q_len), 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk(q_full && !p0_ready && !q_enqueue, "t3_full_wait", 32'({q_full, p0_ready, q_enqueue}), 32'b100);
    end
    @(posedge clk); #2 force_en = 1'b1; force_len = 8'd200;
    @(negedge clk);
    chk(q_full && !q_empty, "t3_len_200_full", 32'({q_full, q_empty}), 32'b10);
    @(posedge clk); #2 force_len = 8'd9;
    @(negedge clk);
    chk(q_full && !q_enqueue, "t3_len_9_full", 32'({q_full, q_enqueue}), 32'b10);
    @(posedge clk); #2 force_en = 1'b0; c_ready = 1'b1;
    wait_rdy(0);
    @(posedge clk); #2 p0_valid = 1'b0;
    drain();

    // two words dequeued in order, capture two cycles after each dequeue pulse
    acc_log.delete();
    lat_log.delete();
    @(posedge clk); #2 p0_data = 8'h55; p0_valid = 1'b1;
    wait_rdy(0);
    @(posedge clk); #2 p0_valid = 1'b0; p1_data = 8'h66; p1_valid = 1'b1;
    wait_rdy(1);
    @(posedge clk); #2 p1_valid = 1'b0;
    drain();
    chk(acc_log.size() == 2, "t4_count", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk(acc_log[0] == 8'h55, "t4_first", 32'(acc_log[0]), 32'h55);
      chk(acc_log[1] == 8'h66, "t4_second", 32'(acc_log[1]), 32'h66);
    end
    chk(lat_log.size() == 2, "t4_lat_count", lat_log.size(), 2);
    foreach (lat_log[i]) chk(lat_log[i] == 2, "t4_latency", lat_log[i], 2);

    // consumer stalled: exactly one word captured
    @(posedge clk); #2 c_ready = 1'b0; deq_cnt = 0; p0_data = 8'h71; p0_valid = 1'b1;
    wait_rdy(0);
    @(posedge clk); #2 p0_data = 8'h72;
    wait_rdy(0);
    @(posedge clk); #2 p0_data = 8'h73;
    wait_rdy(0);
    @(posedge clk); #2 p0_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk(c_valid && c_data == 8'h71, "t5_held", 32'({c_valid, c_data}), 32'h171);
    chk(q_len == 2, "t5_len", 32'(q_len), 2);
    chk(deq_cnt == 1, "t5_one_dequeue", deq_cnt, 1);
    drain();

    // random soak
    seen0 = xfers0;
    seen1 = xfers1;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk); #2;
      if (!p0_ready) begin
        if (xfers0 != seen0) begin seen0 = xfers0; p0_valid = 1'($urandom_range(0, 1)); p0_data = 8'($urandom); end
        else if (!p0_valid) begin if ($urandom_range(0, 3) == 0) begin p0_valid = 1'b1; p0_data = 8'($urandom); end end
        else if ($urandom_range(0, 31) == 0) p0_valid = 1'b0;
      end
      if (!p1_ready) begin
        if (xfers1 != seen1) begin seen1 = xfers1; p1_valid = 1'($urandom_range(0, 1)); p1_data = 8'($urandom); end
        else if (!p1_valid) begin if ($urandom_range(0, 3) == 0) begin p1_valid = 1'b1; p1_data = 8'($urandom); end end
        else if ($urandom_range(0, 31) == 0) p1_valid = 1'b0;
      end
      c_ready = $urandom_range(0, 99) < 40;
    end
    @(posedge clk); #2 p0_valid = 1'b0; p1_valid = 1'b0;
    drain();
    chk(sb.size() == 0 && pend.size() == 0, "no_loss", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
